// File: rtl/trace_pkg.sv
// Shared types for the CPU execution tracer: capture modes, controller states
// and the packed layout of one trace entry.
package trace_pkg;

  localparam int TRACE_ADDR_W  = 32;
  localparam int TRACE_DATA_W  = 32;
  localparam int TRACE_STAMP_W = 16;

  typedef enum logic [1:0] {
    TM_ALL            = 2'd0,
    TM_START_ON_STORE = 2'd1,
    TM_STORES_ONLY    = 2'd2
  } trace_mode_e;

  typedef enum logic [1:0] {
    TS_IDLE    = 2'd0,
    TS_ARMED   = 2'd1,
    TS_CAPTURE = 2'd2,
    TS_DONE    = 2'd3
  } trace_state_e;

  typedef struct packed {
    logic [TRACE_ADDR_W-1:0]  pc;
    logic [TRACE_DATA_W-1:0]  instr;
    logic [TRACE_DATA_W-1:0]  wdata;
    logic                     we;
    logic [TRACE_STAMP_W-1:0] stamp;
  } trace_entry_t;

  // Raw mode encoding 3 is reserved and behaves like "capture every cycle".
  function automatic trace_mode_e decode_mode(input logic [1:0] raw);
    case (raw)
      2'd1:    return TM_START_ON_STORE;
      2'd2:    return TM_STORES_ONLY;
      default: return TM_ALL;
    endcase
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace storage: one write port, one read port with a
// registered output. The read register holds its value when rd_en_i is low,
// which lets the controller keep the presented entry stable under back-pressure.
module trace_ram #(
  parameter int DEPTH = 128,
  parameter int WIDTH = 113,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Storage array: no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Registered read port, cleared by reset so the readout bus starts at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q <= {WIDTH{1'b0}};
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/cpu_trace_buffer.sv
// Execution tracer: samples the processor bus each clock into an on-chip
// buffer with a cycle stamp, then streams the captured entries out over a
// valid/ready interface once the session is done.
module cpu_trace_buffer
  import trace_pkg::*;
#(
  parameter int ADDR_W  = TRACE_ADDR_W,
  parameter int DATA_W  = TRACE_DATA_W,
  parameter int DEPTH   = 128,
  parameter int STAMP_W = TRACE_STAMP_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     arm,
  input  logic [1:0]               mode,
  input  logic [STAMP_W-1:0]       cycle_limit,
  input  logic [ADDR_W-1:0]        pc,
  input  logic [DATA_W-1:0]        instr,
  input  logic [DATA_W-1:0]        write_data,
  input  logic                     mem_we,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [ADDR_W-1:0]        rd_pc,
  output logic [DATA_W-1:0]        rd_instr,
  output logic [DATA_W-1:0]        rd_wdata,
  output logic                     rd_we,
  output logic [STAMP_W-1:0]       rd_stamp
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]      CNT_ZERO   = {CW{1'b0}};
  localparam logic [CW-1:0]      CNT_ONE    = CW'(1);
  localparam logic [CW-1:0]      CNT_LAST   = CW'(DEPTH - 1);
  localparam logic [AW-1:0]      PTR_ZERO   = {AW{1'b0}};
  localparam logic [AW-1:0]      PTR_ONE    = AW'(1);
  localparam logic [STAMP_W-1:0] STAMP_ZERO = {STAMP_W{1'b0}};
  localparam logic [STAMP_W-1:0] STAMP_MAX  = {STAMP_W{1'b1}};

  trace_state_e       state_q, state_d;
  trace_mode_e        mode_q, mode_d;
  logic [STAMP_W-1:0] limit_q, limit_d;
  logic [STAMP_W-1:0] stamp_q, stamp_d, stamp_inc_s;
  logic [AW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d, rd_addr_s;
  logic [CW-1:0]      count_q, count_d;
  logic               rd_valid_q, rd_valid_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic               wr_en_s, rd_en_s, limit_hit_s, start_s;
  trace_entry_t       wr_entry_s, rd_entry_s;

  // The stamp saturates so a long session never aliases back to small values.
  assign stamp_inc_s = (stamp_q == STAMP_MAX) ? stamp_q : stamp_q + STAMP_W'(1);
  // A non-zero limit ends capture in the cycle whose stamp reaches it; that cycle is still logged.
  assign limit_hit_s = (limit_q != STAMP_ZERO) && (stamp_q >= limit_q);
  // arm only starts a session from IDLE or DONE; it is ignored while a session is running.
  assign start_s     = arm && ((state_q == TS_IDLE) || (state_q == TS_DONE));

  // Pack the current bus sample into a trace entry.
  always_comb begin
    wr_entry_s.pc    = TRACE_ADDR_W'(pc);
    wr_entry_s.instr = TRACE_DATA_W'(instr);
    wr_entry_s.wdata = TRACE_DATA_W'(write_data);
    wr_entry_s.we    = mem_we;
    wr_entry_s.stamp = TRACE_STAMP_W'(stamp_q);
  end

  // Session controller: next state, capture writes and readout prefetch.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    limit_d    = limit_q;
    stamp_d    = stamp_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    rd_valid_d = rd_valid_q;
    wr_en_s    = 1'b0;
    rd_en_s    = 1'b0;
    rd_addr_s  = rptr_q;
    if (start_s) begin
      // New session: anything unread is discarded, arm wins over a readout handshake.
      state_d    = TS_ARMED;
      mode_d     = decode_mode(mode);
      limit_d    = cycle_limit;
      stamp_d    = STAMP_ZERO;
      wptr_d     = PTR_ZERO;
      rptr_d     = PTR_ZERO;
      count_d    = CNT_ZERO;
      rd_valid_d = 1'b0;
    end else begin
      case (state_q)
        TS_IDLE: begin
          state_d = TS_IDLE;
        end
        TS_ARMED: begin
          stamp_d = stamp_inc_s;
          if (mode_q == TM_START_ON_STORE) begin
            if (mem_we) begin
              // The triggering store is the first entry of the trace.
              wr_en_s = 1'b1;
              wptr_d  = wptr_q + PTR_ONE;
              count_d = count_q + CNT_ONE;
              if (limit_hit_s) begin
                state_d = TS_DONE;
              end else begin
                state_d = TS_CAPTURE;
              end
            end else begin
              state_d = TS_ARMED;
            end
          end else begin
            state_d = TS_CAPTURE;
          end
        end
        TS_CAPTURE: begin
          stamp_d = stamp_inc_s;
          if (mode_q == TM_STORES_ONLY) begin
            wr_en_s = mem_we;
          end else begin
            wr_en_s = 1'b1;
          end
          if (wr_en_s) begin
            wptr_d  = wptr_q + PTR_ONE;
            count_d = count_q + CNT_ONE;
          end else begin
            wptr_d  = wptr_q;
            count_d = count_q;
          end
          // Stop on the write that fills the buffer, so nothing is ever overwritten.
          if ((wr_en_s && (count_q == CNT_LAST)) || limit_hit_s) begin
            state_d = TS_DONE;
          end else begin
            state_d = TS_CAPTURE;
          end
        end
        TS_DONE: begin
          if (!rd_valid_q) begin
            // Prefetch the head entry; it shows up on the read register next cycle.
            if (count_q != CNT_ZERO) begin
              rd_en_s    = 1'b1;
              rd_valid_d = 1'b1;
            end else begin
              rd_valid_d = 1'b0;
            end
          end else if (rd_ready) begin
            rptr_d  = rptr_q + PTR_ONE;
            count_d = count_q - CNT_ONE;
            if (count_q == CNT_ONE) begin
              rd_valid_d = 1'b0;
              state_d    = TS_IDLE;
            end else begin
              // Fetch the following entry so back-to-back handshakes run at full rate.
              rd_en_s   = 1'b1;
              rd_addr_s = rptr_q + PTR_ONE;
            end
          end else begin
            rd_valid_d = 1'b1;
          end
        end
        default: begin
          state_d = TS_IDLE;
        end
      endcase
    end
  end

  // Status flags are registered from the next state so they line up with state_q.
  always_comb begin
    busy_d = (state_d == TS_ARMED) || (state_d == TS_CAPTURE);
    done_d = (state_d == TS_DONE);
  end

  // Controller state registers; reset abandons any session in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= TS_IDLE;
      mode_q     <= TM_ALL;
      limit_q    <= STAMP_ZERO;
      stamp_q    <= STAMP_ZERO;
      wptr_q     <= PTR_ZERO;
      rptr_q     <= PTR_ZERO;
      count_q    <= CNT_ZERO;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      limit_q    <= limit_d;
      stamp_q    <= stamp_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(trace_entry_t))
  ) u_trace_ram (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (wr_en_s),
    .wr_addr_i (wptr_q),
    .wr_data_i (wr_entry_s),
    .rd_en_i   (rd_en_s),
    .rd_addr_i (rd_addr_s),
    .rd_data_o (rd_entry_s)
  );

  assign busy     = busy_q;
  assign done     = done_q;
  assign count    = count_q;
  assign rd_valid = rd_valid_q;
  assign rd_pc    = ADDR_W'(rd_entry_s.pc);
  assign rd_instr = DATA_W'(rd_entry_s.instr);
  assign rd_wdata = DATA_W'(rd_entry_s.wdata);
  assign rd_we    = rd_entry_s.we;
  assign rd_stamp = STAMP_W'(rd_entry_s.stamp);

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed bench for cpu_trace_buffer: expected entries are queued as the
// bus is driven and compared as they stream out of the readout port.
module tb_cpu_trace_buffer;

  logic         clk = 1'b0;
  logic         reset;
  logic         arm;
  logic [1:0]   mode;
  logic [15:0]  cycle_limit;
  logic [31:0]  pc, instr, write_data;
  logic         mem_we;
  logic         busy, done, rd_valid, rd_ready, rd_we;
  logic [7:0]   count;
  logic [31:0]  rd_pc, rd_instr, rd_wdata;
  logic [15:0]  rd_stamp;

  logic [112:0] sb[$];
  int           n_chk = 0;
  int           n_err = 0;

  cpu_trace_buffer dut (
    .clk         (clk),
    .reset       (reset),
    .arm         (arm),
    .mode        (mode),
    .cycle_limit (cycle_limit),
    .pc          (pc),
    .instr       (instr),
    .write_data  (write_data),
    .mem_we      (mem_we),
    .busy        (busy),
    .done        (done),
    .count       (count),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_pc       (rd_pc),
    .rd_instr    (rd_instr),
    .rd_wdata    (rd_wdata),
    .rd_we       (rd_we),
    .rd_stamp    (rd_stamp)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=no finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cpu(input int k, input logic we);
    pc         = 32'(k * 4);
    instr      = 32'hA000_0000 | 32'(k);
    write_data = 32'hD000_0000 | 32'(k);
    mem_we     = we;
  endtask

  task automatic push_exp(input logic [15:0] stamp);
    sb.push_back({pc, instr, write_data, mem_we, stamp});
  endtask

  task automatic arm_session(input logic [1:0] m, input logic [15:0] lim);
    mode        = m;
    cycle_limit = lim;
    arm         = 1'b1;
    step();
    arm         = 1'b0;
  endtask

  task automatic status(input string tag, input logic b, input logic d, input logic [7:0] c);
    chk({tag, "_busy"},  128'(busy),  128'(b));
    chk({tag, "_done"},  128'(done),  128'(d));
    chk({tag, "_count"}, 128'(count), 128'(c));
  endtask

  // Drain the scoreboard; the head is compared every valid cycle, so a stalled entry must hold.
  task automatic drain(input string tag, input int budget, input bit random_ready);
    int cyc = 0;
    while (sb.size() > 0 && cyc < budget) begin
      rd_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rd_valid) begin
        chk(tag, {15'd0, rd_pc, rd_instr, rd_wdata, rd_we, rd_stamp}, {15'd0, sb[0]});
        if (rd_ready) void'(sb.pop_front());
      end
      step();
      cyc++;
    end
    rd_ready = 1'b0;
    chk({tag, "_left"}, 128'(sb.size()), 128'(0));
    sb.delete();
    chk({tag, "_end_valid"}, 128'(rd_valid), 128'(1'b0));
    status({tag, "_end"}, 1'b0, 1'b0, 8'd0);
  endtask

  initial begin
    reset = 1'b1; arm = 1'b0; mode = 2'd0; cycle_limit = 16'd0; rd_ready = 1'b0;
    set_cpu(0, 1'b0);

    // 1: reset held three cycles then released
    repeat (3) step();
    reset = 1'b0;
    step();
    status("rst", 1'b0, 1'b0, 8'd0);
    chk("rst_valid", 128'(rd_valid), 128'(1'b0));
    chk("rst_rd", {15'd0, rd_pc, rd_instr, rd_wdata, rd_we, rd_stamp}, 128'd0);

    // 2: every cycle, limit 5 -> stamps 1..5, pc 0x0..0x10
    arm_session(2'd0, 16'd5);
    status("t2_armed", 1'b1, 1'b0, 8'd0);
    set_cpu(100, 1'b0);
    step();
    for (int c = 1; c <= 5; c++) begin
      set_cpu(c - 1, 1'b0);
      push_exp(16'(c));
      step();
    end
    status("t2_done", 1'b0, 1'b1, 8'd5);
    drain("t2_entry", 40, 1'b0);

    // 3: start on the first store at pc 0x20, limit 8
    arm_session(2'd1, 16'd8);
    for (int k = 1; k <= 4; k++) begin
      set_cpu(3 + k, 1'b0);
      step();
    end
    status("t3_wait", 1'b1, 1'b0, 8'd0);
    set_cpu(8, 1'b1);
    push_exp(16'd4);
    step();
    status("t3_trig", 1'b1, 1'b0, 8'd1);
    for (int c = 5; c <= 8; c++) begin
      set_cpu(c + 4, 1'b0);
      push_exp(16'(c));
      step();
    end
    status("t3_done", 1'b0, 1'b1, 8'd5);
    drain("t3_entry", 40, 1'b0);

    // 4: stores only, no limit, a store every 4th cycle
    arm_session(2'd2, 16'd0);
    set_cpu(0, 1'b0);
    step();
    for (int c = 1; c <= 512; c++) begin
      set_cpu(c, (c % 4) == 0);
      if ((c % 4) == 0) push_exp(16'(c));
      step();
      if (c == 200) status("t4_200", 1'b1, 1'b0, 8'd50);
    end
    status("t4_full", 1'b0, 1'b1, 8'd128);
    drain("t4_entry", 300, 1'b0);

    // 5: fill all 128 entries, extra cycles must not be logged, stalled readout
    arm_session(2'd0, 16'd0);
    set_cpu(0, 1'b0);
    step();
    for (int c = 1; c <= 128; c++) begin
      set_cpu(c, 1'b0);
      push_exp(16'(c));
      step();
    end
    for (int i = 0; i < 3; i++) begin
      set_cpu(300 + i, 1'b1);
      step();
    end
    status("t5_full", 1'b0, 1'b1, 8'd128);
    drain("t5_entry", 1000, 1'b1);

    // 6a: reset in the middle of a capture
    arm_session(2'd0, 16'd0);
    set_cpu(0, 1'b0);
    step();
    for (int c = 1; c <= 10; c++) begin
      set_cpu(c, 1'b0);
      step();
    end
    status("t6_mid", 1'b1, 1'b0, 8'd10);
    #2 reset = 1'b1;
    #1;
    status("t6_rst", 1'b0, 1'b0, 8'd0);
    chk("t6_rst_valid", 128'(rd_valid), 128'(1'b0));
    step();
    reset = 1'b0;

    // 6b: arm in DONE together with a readout handshake; old entries discarded
    arm_session(2'd0, 16'd3);
    step();
    for (int c = 1; c <= 3; c++) begin
      set_cpu(c + 50, 1'b0);
      step();
    end
    status("t6_done", 1'b0, 1'b1, 8'd3);
    for (int i = 0; i < 4 && !rd_valid; i++) step();
    chk("t6_prefetch", 128'(rd_valid), 128'(1'b1));
    rd_ready = 1'b1;
    arm_session(2'd3, 16'd2);
    rd_ready = 1'b0;
    status("t6_rearm", 1'b1, 1'b0, 8'd0);
    chk("t6_rearm_valid", 128'(rd_valid), 128'(1'b0));
    step();
    for (int c = 1; c <= 2; c++) begin
      set_cpu(c + 60, 1'b0);
      push_exp(16'(c));
      step();
    end
    status("t6_done2", 1'b0, 1'b1, 8'd2);
    drain("t6_entry", 40, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
